// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV32I pipeline control slice: opcode constants,
// controller state and forwarding-select encodings, the hazard scoreboard
// entry layout, and small opcode-classification helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_BUBBLE = 7'b0000000;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
    logic       is_mem;
  } sb_entry_t;

  // A zero opcode is the bubble the decoder produces, so it never writes.
  function automatic logic op_writes_rd(input logic [6:0] op);
    return (op != OPC_BUBBLE) && (op != OPC_STORE) && (op != OPC_BRANCH);
  endfunction

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return (op != OPC_LUI) && (op != OPC_AUIPC) && (op != OPC_JAL);
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
  endfunction

  // Invalid slots are kept all-zero so no stale flag can leak into a compare.
  function automatic sb_entry_t make_entry(input logic       valid,
                                           input logic [6:0] op,
                                           input logic [4:0] rd);
    sb_entry_t e;
    e = '0;
    if (valid) begin
      e.valid   = 1'b1;
      e.rd      = rd;
      e.wr      = op_writes_rd(op);
      e.is_load = (op == OPC_LOAD);
      e.is_mem  = (op == OPC_LOAD) || (op == OPC_STORE);
    end
    return e;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Two-entry (EX, MEM) record of in-flight instructions plus the forwarding
// and load-use comparisons against the registers read by the ID instruction.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hold              freeze both entries
//   stall             ID instruction is being bubbled this cycle
//   id_valid, id_*    ID instruction fields
//   fwd_a, fwd_b      forwarding selects for EX operands A/B
//   load_use          EX holds a load whose rd is used by ID
//   mem_pending       MEM holds a valid load/store
module hazard_scoreboard
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       stall,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use,
  output logic       mem_pending
);

  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t id_entry;

  always_comb begin
    id_entry = make_entry(id_valid && !stall, id_opcode, id_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!hold) begin
      mem_q <= ex_q;
      ex_q  <= id_entry;
    end
  end

  // A load result in EX is not available yet, so EX only forwards ALU results;
  // that case is covered by the load-use stall instead.
  function automatic fwd_sel_t fwd_for(input logic [4:0] rs,
                                       input sb_entry_t  ex,
                                       input sb_entry_t  mem);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (ex.valid && ex.wr && !ex.is_load && (ex.rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (mem.valid && mem.wr && (mem.rd == rs)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  assign fwd_a = fwd_for(id_rs1, ex_q, mem_q);
  assign fwd_b = fwd_for(id_rs2, ex_q, mem_q);

  assign load_use = id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                    ((op_uses_rs1(id_opcode) && (ex_q.rd == id_rs1)) ||
                     (op_uses_rs2(id_opcode) && (ex_q.rd == id_rs2)));

  assign mem_pending = mem_q.valid && mem_q.is_mem;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline. Handles
// load-use stalls, taken-branch/jump squashing and data-memory wait states,
// and drives operand forwarding selects.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   id_valid, id_*    ID instruction: valid, opcode, rs1, rs2, rd
//   ex_branch_taken   EX redirects the PC this cycle
//   dmem_ready        data memory completes the MEM access
//   stall             bubble the ID instruction
//   pc_en             PC update enable
//   if_flush          invalidate IF/ID
//   hold              freeze IF..MEM pipeline registers
//   fwd_a, fwd_b      EX operand sources (00 RF, 01 EX/MEM, 10 MEM/WB)
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_branch_taken,
  input  logic       dmem_ready,
  output logic       stall,
  output logic       pc_en,
  output logic       if_flush,
  output logic       hold,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        load_use;
  logic        mem_pending;
  logic        mem_wait;

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .stall       (stall),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .load_use    (load_use),
    .mem_pending (mem_pending)
  );

  assign mem_wait = mem_pending && !dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM_WAIT behaves like RUN once memory answers, so both share one branch.
  // A memory wait inside FLUSH keeps the state and freezes the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FLUSH: begin
        if (!mem_wait) begin
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  // Reset is decoded combinationally so the outputs change without a clock.
  always_comb begin
    stall    = 1'b0;
    pc_en    = 1'b1;
    if_flush = 1'b0;
    hold     = 1'b0;
    if (rst) begin
      stall = 1'b1;
      pc_en = 1'b0;
    end else if (mem_wait) begin
      hold  = 1'b1;
      pc_en = 1'b0;
    end else if (state_q == FLUSH) begin
      stall = 1'b1;
    end else if (ex_branch_taken) begin
      stall    = 1'b1;
      if_flush = 1'b1;
    end else if (load_use) begin
      stall = 1'b1;
      pc_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Drives two controllers (FLUSH_CYCLES=2 and =1) with identical stimulus and
// compares both against an instruction-level reference model of the pipeline.
module tb_pipeline_ctrl;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       ex_branch_taken;
  logic       dmem_ready;

  logic       stall_o    [2];
  logic       pc_en_o    [2];
  logic       if_flush_o [2];
  logic       hold_o     [2];
  logic [1:0] fwd_a_o    [2];
  logic [1:0] fwd_b_o    [2];

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
    .stall(stall_o[0]), .pc_en(pc_en_o[0]), .if_flush(if_flush_o[0]),
    .hold(hold_o[0]), .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0])
  );

  pipeline_ctrl #(.FLUSH_CYCLES(1)) dut_fc1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
    .stall(stall_o[1]), .pc_en(pc_en_o[1]), .if_flush(if_flush_o[1]),
    .hold(hold_o[1]), .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1])
  );

  int pass_cnt  = 0;
  int check_cnt = 0;
  int fail_cnt  = 0;

  // Model: the instructions sitting in EX and MEM, plus how many more
  // squash cycles remain after a redirect.
  typedef struct {
    bit         ev;
    logic [6:0] eop;
    logic [4:0] erd;
    bit         mv;
    logic [6:0] mop;
    logic [4:0] mrd;
    int         left;
  } mdl_t;

  typedef struct {
    logic       stall;
    logic       pc_en;
    logic       if_flush;
    logic       hold;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  mdl_t m [2];
  int   fc [2] = '{2, 1};
  logic [6:0] ops [9] = '{LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC};

  function automatic bit writes(input logic [6:0] op);
    return !(op inside {7'b0, STORE, BRANCH});
  endfunction

  function automatic bit reads1(input logic [6:0] op);
    return !(op inside {LUI, AUIPC, JAL});
  endfunction

  function automatic bit reads2(input logic [6:0] op);
    return op inside {OP, STORE, BRANCH};
  endfunction

  function automatic logic [1:0] fwd_model(input int i, input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (m[i].ev && writes(m[i].eop) && m[i].eop != LOAD && m[i].erd == rs) return 2'b01;
    if (m[i].mv && writes(m[i].mop) && m[i].mrd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t predict(input int i);
    exp_t e;
    bit   mem_busy;
    bit   lu;
    e.stall = 0; e.pc_en = 1; e.if_flush = 0; e.hold = 0;
    e.fa = fwd_model(i, id_rs1);
    e.fb = fwd_model(i, id_rs2);
    if (rst) begin
      e.stall = 1; e.pc_en = 0; e.fa = 2'b00; e.fb = 2'b00;
      return e;
    end
    mem_busy = m[i].mv && (m[i].mop inside {LOAD, STORE}) && !dmem_ready;
    lu = id_valid && m[i].ev && m[i].eop == LOAD && m[i].erd != 0 &&
         ((reads1(id_opcode) && m[i].erd == id_rs1) ||
          (reads2(id_opcode) && m[i].erd == id_rs2));
    if (mem_busy) begin
      e.hold = 1; e.pc_en = 0;
    end else if (m[i].left > 0) begin
      e.stall = 1;
    end else if (ex_branch_taken) begin
      e.stall = 1; e.if_flush = 1;
    end else if (lu) begin
      e.stall = 1; e.pc_en = 0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e = predict(i);
      check($sformatf("%s/fc%0d/stall", tag, fc[i]), {1'b0, stall_o[i]}, {1'b0, e.stall});
      check($sformatf("%s/fc%0d/pc_en", tag, fc[i]), {1'b0, pc_en_o[i]}, {1'b0, e.pc_en});
      check($sformatf("%s/fc%0d/if_flush", tag, fc[i]), {1'b0, if_flush_o[i]}, {1'b0, e.if_flush});
      check($sformatf("%s/fc%0d/hold", tag, fc[i]), {1'b0, hold_o[i]}, {1'b0, e.hold});
      check($sformatf("%s/fc%0d/fwd_a", tag, fc[i]), fwd_a_o[i], e.fa);
      check($sformatf("%s/fc%0d/fwd_b", tag, fc[i]), fwd_b_o[i], e.fb);
    end
  endtask

  task automatic expectOut(input string tag, input int i, input logic s, input logic p,
                           input logic f, input logic h);
    check($sformatf("%s/direct%0d/stall", tag, i), {1'b0, stall_o[i]}, {1'b0, s});
    check($sformatf("%s/direct%0d/pc_en", tag, i), {1'b0, pc_en_o[i]}, {1'b0, p});
    check($sformatf("%s/direct%0d/if_flush", tag, i), {1'b0, if_flush_o[i]}, {1'b0, f});
    check($sformatf("%s/direct%0d/hold", tag, i), {1'b0, hold_o[i]}, {1'b0, h});
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic br, input logic rdy);
    id_valid        = v;
    id_opcode       = op;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_rd           = rd;
    ex_branch_taken = br;
    dmem_ready      = rdy;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m[i].ev = 0; m[i].eop = '0; m[i].erd = '0;
      m[i].mv = 0; m[i].mop = '0; m[i].mrd = '0;
      m[i].left = 0;
    end
  endtask

  // Commit the current cycle into the model, then move to just after the edge.
  task automatic advance();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e = predict(i);
      if (!e.hold) begin
        if (m[i].left > 0) m[i].left = m[i].left - 1;
        else if (ex_branch_taken) m[i].left = fc[i] - 1;
        m[i].mv  = m[i].ev;
        m[i].mop = m[i].eop;
        m[i].mrd = m[i].erd;
        m[i].ev  = id_valid && !e.stall;
        m[i].eop = id_opcode;
        m[i].erd = id_rd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 7'b0, 0, 0, 0, 0, 1);
    modelReset();
    #1;
    checkOutput("reset");
    expectOut("reset", 0, 1, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    sample("post_reset");
    expectOut("post_reset", 0, 0, 1, 0, 0);
    advance();

    // lw x5,0(x1) ; add x6,x5,x2
    applyStimulus(1, LOAD, 1, 0, 5, 0, 1);
    sample("lu_lw");
    advance();
    applyStimulus(1, OP, 5, 2, 6, 0, 1);
    sample("lu_add");
    expectOut("lu_stall", 0, 1, 0, 0, 0);
    advance();
    applyStimulus(1, OP, 5, 2, 6, 0, 1);
    sample("lu_resume");
    expectOut("lu_resume", 0, 0, 1, 0, 0);
    check("lu_fwd_a", fwd_a_o[0], 2'b10);
    advance();

    // Same with rd=x0: no hazard
    applyStimulus(1, LOAD, 1, 0, 0, 0, 1);
    sample("lu0_lw");
    advance();
    applyStimulus(1, OP, 0, 2, 6, 0, 1);
    sample("lu0_add");
    expectOut("lu0_add", 0, 0, 1, 0, 0);
    advance();

    // add x3 ; sub x3 ; or x4,x3,x3
    applyStimulus(1, OP, 1, 2, 3, 0, 1);
    sample("prio_add");
    advance();
    applyStimulus(1, OP, 1, 2, 3, 0, 1);
    sample("prio_sub");
    advance();
    applyStimulus(1, OP, 3, 3, 4, 0, 1);
    sample("prio_or");
    check("prio_fwd_a", fwd_a_o[0], 2'b01);
    check("prio_fwd_b", fwd_b_o[0], 2'b01);
    advance();

    // Taken branch pulse at T
    applyStimulus(1, OP_IMM, 1, 0, 7, 1, 1);
    sample("br_T");
    expectOut("br_T", 0, 1, 1, 1, 0);
    expectOut("br_T", 1, 1, 1, 1, 0);
    advance();
    applyStimulus(1, OP_IMM, 1, 0, 7, 0, 1);
    sample("br_T1");
    expectOut("br_T1", 0, 1, 1, 0, 0);
    expectOut("br_T1", 1, 0, 1, 0, 0);
    advance();
    applyStimulus(1, OP_IMM, 1, 0, 7, 0, 1);
    sample("br_T2");
    expectOut("br_T2", 0, 0, 1, 0, 0);
    advance();

    // Store stalls in MEM for 3 cycles while EX presents a taken branch
    applyStimulus(1, STORE, 1, 2, 0, 0, 1);
    sample("mw_sw");
    advance();
    applyStimulus(1, OP, 1, 1, 8, 0, 1);
    sample("mw_add");
    advance();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, OP_IMM, 8, 0, 9, 1, 0);
      sample($sformatf("mw_wait%0d", k));
      expectOut("mw_wait", 0, 0, 0, 0, 1);
      expectOut("mw_wait", 1, 0, 0, 0, 1);
      check("mw_fwd_a", fwd_a_o[0], 2'b01);
      advance();
    end
    applyStimulus(1, OP_IMM, 8, 0, 9, 1, 1);
    sample("mw_ready");
    expectOut("mw_ready", 0, 1, 1, 1, 0);
    expectOut("mw_ready", 1, 1, 1, 1, 0);
    advance();
    applyStimulus(0, 7'b0, 0, 0, 0, 0, 1);
    sample("mw_flush");
    expectOut("mw_flush", 0, 1, 1, 0, 0);
    advance();
    applyStimulus(0, 7'b0, 0, 0, 0, 0, 1);
    sample("mw_idle");
    advance();

    // Branch and load-use in the same cycle
    applyStimulus(1, LOAD, 1, 0, 5, 0, 1);
    sample("sim_lw");
    advance();
    applyStimulus(1, OP, 5, 2, 6, 1, 1);
    sample("sim_both");
    expectOut("sim_both", 0, 1, 1, 1, 0);
    advance();
    applyStimulus(0, 7'b0, 0, 0, 0, 0, 1);
    sample("sim_flush");
    advance();

    // Reset in the middle of FLUSH
    applyStimulus(1, OP, 1, 2, 9, 0, 1);
    sample("rf_add");
    advance();
    applyStimulus(0, 7'b0, 0, 0, 0, 1, 1);
    sample("rf_br");
    advance();
    applyStimulus(1, OP, 9, 9, 10, 0, 1);
    #1;
    checkOutput("rf_pre");
    check("rf_pre_fwd_a", fwd_a_o[0], 2'b10);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rf_in_rst");
    expectOut("rf_in_rst", 0, 1, 0, 0, 0);
    check("rf_in_rst_fwd_a", fwd_a_o[0], 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, OP, 9, 9, 10, 0, 1);
    sample("rf_after");
    expectOut("rf_after", 0, 0, 1, 0, 0);
    check("rf_after_fwd_a", fwd_a_o[0], 2'b00);
    check("rf_after_fwd_b", fwd_b_o[0], 2'b00);
    advance();

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                    ops[$urandom_range(0, 8)],
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0);
      sample($sformatf("rand%0d", n));
      advance();
    end

    if (fail_cnt != 0) $display("[TB] %0d comparisons did not match", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
